dsp_mac_sequencer: RTL
======================

// Module: dsp_mac_sequencer
// PURPOSE
//  Sequences one DSP_Project slice as a multiply-accumulate engine: takes a job length, streams
//  18-bit operand pairs in over valid/ready, drives DSP A/B/OPMODE/clock-enables so that P = sum(A_i*B_i),
//  and returns the 48-bit result over valid/ready. The slice uses A0REG=0,A1REG=1,B0REG=0,B1REG=1,MREG=1,PREG=1,OPMODEREG=1.
// PARAMETERS
//  LEN_W     8   width of job length / element counter
// PORTS
//  CLK          in   1   clock, all state on rising edge
//  RST          in   1   asynchronous, active-high reset
//  START        in   1   job request; accepted only in IDLE with LEN!=0
//  LEN          in   LEN_W  number of operand pairs, sampled with START
//  BUSY         out  1   high in RUN/DRAIN/DONE
//  OP_VALID     in   1   operand pair valid
//  OP_READY     out  1   high only in RUN
//  OP_A, OP_B   in   18  operands (unsigned, as the slice multiplies)
//  RES_VALID    out  1   result valid, held until RES_READY
//  RES_READY    in   1   result consumer ready
//  RES          out  48  = DSP_P (pass-through), meaningful while RES_VALID
//  DSP_A,DSP_B  out  18  = OP_A/OP_B (combinational)
//  DSP_CEA,DSP_CEB out 1 = OP_VALID & OP_READY
//  DSP_CEM      out  1   = tag v1 (pair resident in A1/B1)
//  DSP_CEP      out  1   = tag v2 (product resident in M)
//  DSP_OPMODE   out  8   first-tag f1 ? OP_FIRST : OP_ACC; DSP_CEOPMODE = v1
//  DSP_P        in   48  slice P output
// BEHAVIOUR
//  - Reset: state IDLE, counter 0, tags 0; BUSY, OP_READY, RES_VALID, all DSP_CE* = 0, DSP_OPMODE = OP_FIRST.
//  - FSM: IDLE -START&LEN!=0-> RUN (cnt=LEN); RUN: each handshake cnt--, on last handshake -> DRAIN;
//    DRAIN -> DONE on the edge DSP_CEP fires with the last tag; DONE -RES_READY-> IDLE.
//  - START with LEN=0, or START outside IDLE: ignored, no state change.
//  - Tag pipe: handshake at edge k sets v1/f1 (f1=first element of job); edge k+1 moves v1/f1 -> v2;
//    OPMODE register loads at k+1 alongside M, so OPMODE_wire aligns with M_out; P captures at k+2.
//  - OP_FIRST = 8'b0000_0001 (X=M, Z=0, add, carry 0, no pre-adder); OP_ACC = 8'b0000_1001 (X=M, Z=P).
//  - Gaps (OP_VALID low) insert bubbles: v1/v2 = 0 so M and P hold; no double accumulation.
//  - Latency: last handshake at edge k -> RES_VALID high from edge k+2; RES stable while RES_READY low (CEP=0).
//  - Result width: 48-bit wrap, no saturation; CARRYOUT ignored.
//  - RST mid-job: job discarded immediately; slice contents stale but next job's first element uses Z=0.
//  - RES handshake and START in same cycle: START ignored (accepted from IDLE next cycle).
// CONFIGURATION
//  `define DSP_MAC_BIAS_EN: adds ports BIAS in 48, DSP_C out 48, DSP_CEC out 1.
//    BIAS sampled with START into a holding reg driving DSP_C; DSP_CEC pulses 1 cycle after START accept
//    (C loaded before first product reaches post-adder); OP_FIRST becomes 8'b0000_1101 (Z=C): P = BIAS + sum.
//  Without it: no bias ports, OP_FIRST = 8'b0000_0001, result = sum only.
// STRUCTURE
//  Package dsp_mac_pkg: OP_FIRST/OP_ACC (and bias variant) constants, FSM state encoding
//  (IDLE, RUN, DRAIN, DONE), DSP operand/accumulator widths (18, 48).
//  Sub-module mac_tag_pipe: 2-stage {valid,first} shift register producing v1/f1/v2.
//  Top instantiates FSM + counter + mac_tag_pipe; DSP slice instantiated by integrating testbench/top.
// TESTING (bench instantiates DSP_Project with parameters listed in PURPOSE)
//  1 LEN=3, pairs (1,2),(3,4),(5,6) back-to-back -> RES=44, RES_VALID 2 cycles after last accept.
//  2 Same job with OP_VALID low 2 cycles between each pair -> RES=44; DSP_CEM/CEP only on real data.
//  3 RES_READY low 5 cycles in DONE -> RES held at 44, OP_READY 0, BUSY 1; then IDLE after handshake.
//  4 START with LEN=0 -> no state change, BUSY stays 0; START while RUN -> ignored, count unaffected.
//  5 RST pulsed mid-RUN after 1 of 3 pairs, then LEN=1 (7,8) -> RES=56 (no stale accumulation).
//  6 LEN=4 of (0x3FFFF,0x3FFFF) -> RES=4*0xFFFF8_0001=0x3FFFE00004; with DSP_MAC_BIAS_EN,
//    BIAS=100, LEN=1 (7,8) -> RES=156.

Source files
------------

// File: rtl/dsp_mac_pkg.sv
// Shared constants for the DSP multiply-accumulate sequencer.
// The bias build (`DSP_MAC_BIAS_EN) makes the first-element opcode add the C port.
package dsp_mac_pkg;

  localparam int DSP_A_W = 18;
  localparam int DSP_P_W = 48;

  // X=M, Z=P: accumulate onto the running sum.
  localparam logic [7:0] OP_ACC = 8'b0000_1001;
`ifdef DSP_MAC_BIAS_EN
  localparam logic [7:0] OP_FIRST = 8'b0000_1101;
`else
  localparam logic [7:0] OP_FIRST = 8'b0000_0001;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/mac_tag_pipe.sv
// Two-stage {valid, first} tag pipe that tracks which DSP pipeline stages hold real data:
// v1/f1 = operand pair in A1/B1, v2 = product in M.
module mac_tag_pipe (
  input  logic clk,
  input  logic rst,
  input  logic hs,
  input  logic first,
  output logic v1,
  output logic f1,
  output logic v2
);

  logic v1_reg;
  logic f1_reg;
  logic v2_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_reg <= 1'b0;
      f1_reg <= 1'b0;
      v2_reg <= 1'b0;
    end else begin
      v1_reg <= hs;
      f1_reg <= hs & first;
      v2_reg <= v1_reg;
    end
  end

  assign v1 = v1_reg;
  assign f1 = f1_reg;
  assign v2 = v2_reg;

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Drives one DSP slice as a MAC engine: P = sum(A_i*B_i) over a job of LEN operand pairs.
// Optional `DSP_MAC_BIAS_EN adds a per-job bias loaded into the C port.
module dsp_mac_sequencer
  import dsp_mac_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               START,
  input  logic [LEN_W-1:0]   LEN,
  output logic               BUSY,
  input  logic               OP_VALID,
  output logic               OP_READY,
  input  logic [DSP_A_W-1:0] OP_A,
  input  logic [DSP_A_W-1:0] OP_B,
  output logic               RES_VALID,
  input  logic               RES_READY,
  output logic [DSP_P_W-1:0] RES,
  output logic [DSP_A_W-1:0] DSP_A,
  output logic [DSP_A_W-1:0] DSP_B,
  output logic               DSP_CEA,
  output logic               DSP_CEB,
  output logic               DSP_CEM,
  output logic               DSP_CEP,
  output logic [7:0]         DSP_OPMODE,
  output logic               DSP_CEOPMODE,
  input  logic [DSP_P_W-1:0] DSP_P
`ifdef DSP_MAC_BIAS_EN
  ,
  input  logic [DSP_P_W-1:0] BIAS,
  output logic [DSP_P_W-1:0] DSP_C,
  output logic               DSP_CEC
`endif
);

  state_t           state_reg;
  logic [LEN_W-1:0] cnt_reg;
  logic             first_pending_reg;
  logic             busy_reg;
  logic             op_ready_reg;
  logic             res_valid_reg;
  logic             hs;
  logic             start_accept;
  logic             v1, f1, v2;

  assign hs           = OP_VALID & op_ready_reg;
  assign start_accept = START && (state_reg == IDLE) && (LEN != '0);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg         <= IDLE;
      cnt_reg           <= '0;
      first_pending_reg <= 1'b0;
      busy_reg          <= 1'b0;
      op_ready_reg      <= 1'b0;
      res_valid_reg     <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_accept) begin
            state_reg         <= RUN;
            cnt_reg           <= LEN;
            first_pending_reg <= 1'b1;
            busy_reg          <= 1'b1;
            op_ready_reg      <= 1'b1;
          end
        end
        RUN: begin
          if (hs) begin
            cnt_reg           <= cnt_reg - 1'b1;
            first_pending_reg <= 1'b0;
            if (cnt_reg == LEN_W'(1)) begin
              state_reg    <= DRAIN;
              op_ready_reg <= 1'b0;
            end
          end
        end
        DRAIN: begin
          // No new pairs enter here, so v2 with v1 clear is the last product reaching P.
          if (v2 && !v1) begin
            state_reg     <= DONE;
            res_valid_reg <= 1'b1;
          end
        end
        DONE: begin
          if (RES_READY) begin
            state_reg     <= IDLE;
            res_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  mac_tag_pipe u_tag_pipe (
    .clk   (CLK),
    .rst   (RST),
    .hs    (hs),
    .first (first_pending_reg),
    .v1    (v1),
    .f1    (f1),
    .v2    (v2)
  );

  assign BUSY         = busy_reg;
  assign OP_READY     = op_ready_reg;
  assign RES_VALID    = res_valid_reg;
  assign RES          = DSP_P;
  assign DSP_A        = OP_A;
  assign DSP_B        = OP_B;
  assign DSP_CEA      = hs;
  assign DSP_CEB      = hs;
  assign DSP_CEM      = v1;
  assign DSP_CEP      = v2;
  assign DSP_CEOPMODE = v1;
  // Idle opcode defaults to OP_FIRST; it only reaches the slice when v1 enables the load.
  assign DSP_OPMODE   = (f1 || !v1) ? OP_FIRST : OP_ACC;

`ifdef DSP_MAC_BIAS_EN
  logic [DSP_P_W-1:0] bias_reg;
  logic               cec_reg;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      bias_reg <= '0;
      cec_reg  <= 1'b0;
    end else begin
      cec_reg <= start_accept;
      if (start_accept) begin
        bias_reg <= BIAS;
      end
    end
  end

  assign DSP_C   = bias_reg;
  assign DSP_CEC = cec_reg;
`endif

endmodule
